// File: rtl/risc_pkg.sv
// Shared RV32I-subset decode types: opcodes, instruction classes,
// immediate formats and decode bundles.
package risc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  typedef enum logic [5:0] {
    IT_RESET, IT_UNKNOWN,
    IT_LW, IT_SW,
    IT_ADDI, IT_SLLI, IT_SLTI, IT_XORI,
    IT_SRLI, IT_SRAI, IT_ORI, IT_ANDI,
    IT_ADD, IT_SUB, IT_SLL, IT_SLT, IT_XOR,
    IT_SRL, IT_SRA, IT_OR, IT_AND,
    IT_BEQ, IT_BNE, IT_BLT, IT_BGE,
    IT_JALR, IT_JAL, IT_LUI, IT_AUIPC
  } instr_type_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_SHAMT, IMM_S, IMM_B,
    IMM_U, IMM_J, IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } dec_ctrl_t;

  typedef struct packed {
    instr_type_e typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    dec_ctrl_t   ctrl;
  } dec_t;

  function automatic logic writes_rd(
    input instr_type_e t
  );
    return t inside {
      IT_LW, IT_ADDI, IT_SLLI, IT_SLTI,
      IT_XORI, IT_SRLI, IT_SRAI, IT_ORI,
      IT_ANDI, IT_ADD, IT_SUB, IT_SLL,
      IT_SLT, IT_XOR, IT_SRL, IT_SRA,
      IT_OR, IT_AND, IT_JAL, IT_JALR,
      IT_LUI, IT_AUIPC
    };
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decoder: class, register fields,
// formatted immediate and control flags.
module id_decoder
  import risc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        alt;
  instr_type_e typ;
  imm_fmt_e    fmt;
  logic [31:0] imm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign alt = instr[30];

  always_comb begin
    typ = IT_UNKNOWN;
    fmt = IMM_NONE;
    unique case (1'b1)
      (opc == OP_LOAD): begin
        if (f3 == F3_LW) begin
          typ = IT_LW;
          fmt = IMM_I;
        end
      end
      (opc == OP_STORE): begin
        if (f3 == F3_SW) begin
          typ = IT_SW;
          fmt = IMM_S;
        end
      end
      (opc == OP_IMM): begin
        fmt = IMM_I;
        case (f3)
          F3_ADD: typ = IT_ADDI;
          F3_SLL: begin
            typ = IT_SLLI;
            fmt = IMM_SHAMT;
          end
          F3_SLT: typ = IT_SLTI;
          F3_XOR: typ = IT_XORI;
          F3_SR: begin
            typ = alt ? IT_SRAI : IT_SRLI;
            fmt = IMM_SHAMT;
          end
          F3_OR:  typ = IT_ORI;
          F3_AND: typ = IT_ANDI;
          default: begin
            typ = IT_UNKNOWN;
            fmt = IMM_NONE;
          end
        endcase
      end
      (opc == OP_ARITH): begin
        case (f3)
          F3_ADD:  typ = alt ? IT_SUB : IT_ADD;
          F3_SLL:  typ = IT_SLL;
          F3_SLT:  typ = IT_SLT;
          F3_XOR:  typ = IT_XOR;
          F3_SR:   typ = alt ? IT_SRA : IT_SRL;
          F3_OR:   typ = IT_OR;
          F3_AND:  typ = IT_AND;
          default: typ = IT_UNKNOWN;
        endcase
      end
      (opc == OP_BRANCH): begin
        fmt = IMM_B;
        case (f3)
          F3_BEQ: typ = IT_BEQ;
          F3_BNE: typ = IT_BNE;
          F3_BLT: typ = IT_BLT;
          F3_BGE: typ = IT_BGE;
          default: begin
            typ = IT_UNKNOWN;
            fmt = IMM_NONE;
          end
        endcase
      end
      (opc == OP_JALR): begin
        if (f3 == F3_JALR) begin
          typ = IT_JALR;
          fmt = IMM_I;
        end
      end
      (opc == OP_JAL): begin
        typ = IT_JAL;
        fmt = IMM_J;
      end
      (opc == OP_LUI): begin
        typ = IT_LUI;
        fmt = IMM_U;
      end
      (opc == OP_AUIPC): begin
        typ = IT_AUIPC;
        fmt = IMM_U;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_SHAMT:
        imm32 = {27'b0, instr[24:20]};
      IMM_S:
        imm32 = {{20{instr[31]}}, instr[31:25],
                 instr[11:7]};
      IMM_B:
        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
      IMM_U:
        imm32 = {instr[31:12], 12'b0};
      IMM_J:
        imm32 = {{11{instr[31]}}, instr[31],
                 instr[19:12], instr[20],
                 instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  always_comb begin
    dec      = '0;
    dec.typ  = typ;
    dec.rd   = instr[11:7];
    dec.rs1  = instr[19:15];
    dec.rs2  = instr[24:20];
    dec.ctrl.illegal   = (typ == IT_UNKNOWN);
    dec.ctrl.reg_write = writes_rd(typ) &&
                         (instr[11:7] != 5'd0);
    dec.ctrl.mem_read  = (typ == IT_LW);
    dec.ctrl.mem_write = (typ == IT_SW);
    dec.ctrl.branch    = typ inside
      {IT_BEQ, IT_BNE, IT_BLT, IT_BGE};
    dec.ctrl.jump      = typ inside {IT_JAL, IT_JALR};
  end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: decodes fetched instructions into a two-entry
// skid buffer towards execute; counts illegal instructions.
module id_decode_stage
  import risc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_type,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_t            in_dec;
  logic [XLEN-1:0] in_imm;

  logic            main_v, skid_v;
  dec_t            main_d, skid_d;
  logic [XLEN-1:0] main_pc, skid_pc;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic            accept;

  id_decoder #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .dec   (in_dec),
    .imm   (in_imm)
  );

  assign in_ready = !skid_v;
  assign accept   = in_valid && in_ready;

  // Main loads whenever it is empty or draining; skid only
  // catches an accept while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
      main_d   <= '0;
      main_pc  <= '0;
      main_imm <= '0;
      skid_d   <= '0;
      skid_pc  <= '0;
      skid_imm <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        main_v   <= 1'b1;
        main_d   <= skid_d;
        main_pc  <= skid_pc;
        main_imm <= skid_imm;
        skid_v   <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) begin
          main_d   <= in_dec;
          main_pc  <= in_pc;
          main_imm <= in_imm;
        end
      end
    end else if (accept) begin
      skid_v   <= 1'b1;
      skid_d   <= in_dec;
      skid_pc  <= in_pc;
      skid_imm <= in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && !flush &&
                 in_dec.ctrl.illegal &&
                 illegal_cnt != '1) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign out_valid     = main_v;
  assign out_type      = main_d.typ;
  assign out_pc        = main_pc;
  assign out_rd        = main_d.rd;
  assign out_rs1       = main_d.rs1;
  assign out_rs2       = main_d.rs2;
  assign out_imm       = main_imm;
  assign out_reg_write = main_d.ctrl.reg_write;
  assign out_mem_read  = main_d.ctrl.mem_read;
  assign out_mem_write = main_d.ctrl.mem_write;
  assign out_branch    = main_d.ctrl.branch;
  assign out_jump      = main_d.ctrl.jump;
  assign out_illegal   = main_d.ctrl.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode, skid stall,
// flush, illegal counter saturation and async reset.
module tb_id_decode_stage;
  import risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid;
  logic [5:0]  out_type;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_illegal;
  logic [15:0] illegal_cnt;

  logic        d2_in_ready, d2_out_valid;
  logic [5:0]  d2_type;
  logic [31:0] d2_pc, d2_imm;
  logic [4:0]  d2_rd, d2_rs1, d2_rs2;
  logic        d2_rw, d2_mr, d2_mw, d2_br, d2_jp, d2_il;
  logic [1:0]  d2_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SUB  = 32'h40208133;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_SLTU = 32'h00003033;
  localparam logic [31:0] I_NOP  = 32'h00000013;

  always #5 clk = ~clk;

  id_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm),
    .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  id_decode_stage #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(d2_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(d2_out_valid), .out_ready(out_ready),
    .out_type(d2_type), .out_pc(d2_pc),
    .out_rd(d2_rd), .out_rs1(d2_rs1),
    .out_rs2(d2_rs2), .out_imm(d2_imm),
    .out_reg_write(d2_rw), .out_mem_read(d2_mr),
    .out_mem_write(d2_mw), .out_branch(d2_br),
    .out_jump(d2_jp), .out_illegal(d2_il),
    .illegal_cnt(d2_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] ins,
                       input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_type", out_type, IT_RESET);
    check("rst_imm", out_imm, 0);
    check("rst_cnt", illegal_cnt, 0);
    rst_n = 1'b1;
    tick();

    drive(1'b1, I_ADDI, 32'h100);
    tick();
    check("addi_valid", out_valid, 1);
    check("addi_type", out_type, IT_ADDI);
    check("addi_rd", out_rd, 1);
    check("addi_imm", out_imm, 5);
    check("addi_rw", out_reg_write, 1);
    check("addi_pc", out_pc, 32'h100);

    drive(1'b1, I_SUB, 32'h104);
    tick();
    check("sub_type", out_type, IT_SUB);
    check("sub_rd", out_rd, 2);
    check("sub_rs1", out_rs1, 1);
    check("sub_rs2", out_rs2, 2);
    check("sub_rw", out_reg_write, 1);

    drive(1'b1, I_BEQ, 32'h108);
    tick();
    check("beq_type", out_type, IT_BEQ);
    check("beq_imm", out_imm, 32'hFFFFFFFC);
    check("beq_br", out_branch, 1);
    check("beq_rw", out_reg_write, 0);

    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("idle_valid", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h200);
    tick();
    check("st1_pc", out_pc, 32'h200);
    check("st1_ready", in_ready, 1);
    drive(1'b1, I_SUB, 32'h204);
    tick();
    check("st2_pc", out_pc, 32'h200);
    check("st2_ready", in_ready, 0);
    drive(1'b1, I_BEQ, 32'h208);
    tick();
    check("st3_pc", out_pc, 32'h200);
    check("st3_type", out_type, IT_ADDI);
    check("st3_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("dr1_pc", out_pc, 32'h204);
    check("dr1_type", out_type, IT_SUB);
    check("dr1_ready", in_ready, 1);
    tick();
    check("dr2_pc", out_pc, 32'h208);
    check("dr2_type", out_type, IT_BEQ);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("dr3_valid", out_valid, 0);

    out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h300);
    tick();
    drive(1'b1, I_SUB, 32'h304);
    tick();
    check("fl_full", in_ready, 0);
    drive(1'b1, I_BEQ, 32'h308);
    flush = 1'b1;
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    drive(1'b1, I_SLTU, 32'h30C);
    tick();
    check("fl_drop", out_valid, 0);
    check("fl_cnt", illegal_cnt, 0);
    flush = 1'b0;
    out_ready = 1'b1;

    drive(1'b1, I_SLTU, 32'h400);
    tick();
    check("ill_type", out_type, IT_UNKNOWN);
    check("ill_flag", out_illegal, 1);
    check("ill_rw", out_reg_write, 0);
    check("ill_imm", out_imm, 0);
    check("ill_cnt", illegal_cnt, 1);
    tick();
    check("cnt2", illegal_cnt, 2);
    check("sat_a", d2_cnt, 2);
    tick();
    check("sat_b", d2_cnt, 3);
    tick();
    check("sat_c", d2_cnt, 3);
    check("cnt4", illegal_cnt, 4);

    drive(1'b1, I_NOP, 32'h500);
    tick();
    check("nop_type", out_type, IT_ADDI);
    check("nop_rw", out_reg_write, 0);
    check("nop_cnt", illegal_cnt, 4);

    out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h600);
    tick();
    drive(1'b1, I_SUB, 32'h604);
    tick();
    check("rs_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_type", out_type, IT_RESET);
    check("ar_pc", out_pc, 0);
    check("ar_cnt", illegal_cnt, 0);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
